aes_spi_slave: RTL

AES_SPI_SLAVE -- requirements
Module: aes_spi_slave

---
 rtl/aes_spi_slave.sv | 134 +++++++++++++
 1 files changed

// File: rtl/aes_spi_slave.sv
// SPI slave front end for an AES core: receives data+key, starts the core,
// and serves the 128-bit result back to the master over the same link.
module aes_spi_slave #(
  parameter int Nk = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              core_start,
  output logic [127:0]      core_data,
  output logic [Nk*32-1:0]  core_key,
  input  logic              core_done,
  input  logic [127:0]      core_result,
  output logic              busy,
  output logic              frame_err
);

  localparam int W = 128 + Nk*32;
  localparam logic [8:0] RX_LAST = 9'(W);
  localparam logic [7:0] TX_LAST = 8'd128;

  typedef enum logic [2:0] {
    IDLE, RX, START, WAIT_CORE, TX_READY, TX
  } state_t;

  state_t         state, state_nx;
  logic           sclk_q, cs_q;
  logic           rise, fall, cs_rise;
  logic [8:0]     rx_cnt, rx_cnt_up;
  logic [7:0]     tx_cnt, tx_cnt_up;
  logic [W-1:0]   sr;
  logic [127:0]   tx_sr, res_q;
  logic           armed;

  assign rise      = sclk & ~sclk_q;
  assign fall      = ~sclk & sclk_q;
  assign cs_rise   = cs_n & ~cs_q;
  assign rx_cnt_up = rx_cnt + {8'd0, rise};
  assign tx_cnt_up = tx_cnt + {7'd0, rise};

  always_comb begin
    state_nx   = state;
    frame_err  = 1'b0;
    core_start = 1'b0;
    unique case (state)
      IDLE:
        if (!cs_q && armed) state_nx = RX;
      RX:
        if (rx_cnt == RX_LAST) begin
          state_nx = START;
        end else if (cs_rise && rx_cnt_up != RX_LAST) begin
          frame_err = 1'b1;
          state_nx  = IDLE;
        end
      START: begin
        core_start = 1'b1;
        state_nx   = WAIT_CORE;
      end
      WAIT_CORE:
        if (core_done) state_nx = TX_READY;
      TX_READY:
        if (!cs_q) state_nx = TX;
      TX:
        if (tx_cnt == TX_LAST) begin
          state_nx = IDLE;
        end else if (cs_rise && tx_cnt_up != TX_LAST) begin
          state_nx = TX_READY;
        end
      default:
        state_nx = IDLE;
    endcase
    if (rst) begin
      state_nx   = IDLE;
      frame_err  = 1'b0;
      core_start = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sclk_q <= 1'b0;
      cs_q   <= 1'b1;
      rx_cnt <= '0;
      tx_cnt <= '0;
      sr     <= '0;
      tx_sr  <= '0;
      res_q  <= '0;
      armed  <= 1'b1;
    end else begin
      sclk_q <= sclk;
      cs_q   <= cs_n;
      if (cs_q) armed <= 1'b1;
      case (state)
        IDLE: rx_cnt <= '0;
        RX:
          if (frame_err) begin
            sr     <= '0;
            rx_cnt <= '0;
          end else if (rise && rx_cnt != RX_LAST) begin
            sr     <= {sr[W-2:0], mosi};
            rx_cnt <= rx_cnt_up;
          end
        WAIT_CORE:
          if (core_done) begin
            tx_sr <= core_result;
            res_q <= core_result;
          end
        TX_READY: tx_cnt <= '0;
        TX: begin
          if (state_nx == TX_READY) begin
            tx_sr <= res_q;
          end else begin
            if (fall) tx_sr <= tx_sr << 1;
            if (rise && tx_cnt != TX_LAST) tx_cnt <= tx_cnt_up;
          end
          // a master still holding cs_n low must release it before a new frame
          if (tx_cnt == TX_LAST) armed <= 1'b0;
        end
        default: ;
      endcase
      state <= state_nx;
    end
  end

  assign miso = !rst && (state == TX_READY || state == TX) && tx_sr[127];
  assign busy = !rst && (state != IDLE);
  assign core_data = rst ? '0 : sr[W-1 -: 128];
  assign core_key  = rst ? '0 : sr[Nk*32-1:0];

endmodule
